pipe_ctrl: RTL and testbench

- Central pipeline controller for the core. Sequences the PC, IF/ID and ID/EX registers.
- Merges stall and redirect requests from EX (branch/jump, multi-cycle ops), the bus arbiter and the CLINT into one hold flag plus one jump redirect.
- A small FSM enforces the bubble window after every redirect and during interrupt entry.
- Sits beside the PC register and the fetch/decode pipeline registers; its outputs feed all of them.

---
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between EX, bus arbiter, CLINT and the pipeline controller.
// With PIPE_CTRL_PERF_EN defined, it also carries the stall and redirect counters.
interface pipe_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              jump_flag_i;
   logic [ADDR_W-1:0] jump_addr_i;
   logic              ex_hold_i;
   logic              bus_hold_i;
   logic              int_req_i;
   logic [ADDR_W-1:0] int_addr_i;
   logic              int_done_i;
   logic [2:0]        hold_flag_o;
   logic              jump_flag_o;
   logic [ADDR_W-1:0] jump_addr_o;
   logic              busy_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]       stall_cnt_o;
   logic [31:0]       redirect_cnt_o;

   modport master (
      output jump_flag_i, jump_addr_i, ex_hold_i, bus_hold_i, int_req_i, int_addr_i, int_done_i,
      input  hold_flag_o, jump_flag_o, jump_addr_o, busy_o, stall_cnt_o, redirect_cnt_o
   );
   modport slave (
      input  jump_flag_i, jump_addr_i, ex_hold_i, bus_hold_i, int_req_i, int_addr_i, int_done_i,
      output hold_flag_o, jump_flag_o, jump_addr_o, busy_o, stall_cnt_o, redirect_cnt_o
   );
`else
   modport master (
      output jump_flag_i, jump_addr_i, ex_hold_i, bus_hold_i, int_req_i, int_addr_i, int_done_i,
      input  hold_flag_o, jump_flag_o, jump_addr_o, busy_o
   );
   modport slave (
      input  jump_flag_i, jump_addr_i, ex_hold_i, bus_hold_i, int_req_i, int_addr_i, int_done_i,
      output hold_flag_o, jump_flag_o, jump_addr_o, busy_o
   );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall/redirect sources into one hold level and one PC redirect.
// Optional PIPE_CTRL_PERF_EN adds saturating stall and redirect counters.
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int ADDR_W       = 32
) (
   input logic        clk_i,
   input logic        rst_n_i,
   pipe_ctrl_if.slave bus
);
   localparam logic [2:0] HOLD_NONE  = 3'd0;
   localparam logic [2:0] HOLD_PC    = 3'd1;
   localparam logic [2:0] HOLD_ID    = 3'd3;
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam bit         FLUSH_EN   = (FLUSH_CYCLES > 1);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_INT} state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_cnt, w_cnt_nxt;
   logic [2:0]        w_fsm_hold, w_hold;
   logic              w_jump;
   logic [ADDR_W-1:0] w_addr;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_RUN;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fsm_hold  = HOLD_NONE;
      w_jump      = 1'b0;
      w_addr      = '0;
      case (r_state)
         S_RUN: begin
            if (bus.int_req_i) begin
               w_jump      = 1'b1;
               w_addr      = bus.int_addr_i;
               w_fsm_hold  = HOLD_ID;
               w_state_nxt = S_INT;
               w_cnt_nxt   = 3'd0;
            end else if (bus.jump_flag_i) begin
               w_jump     = 1'b1;
               w_addr     = bus.jump_addr_i;
               w_fsm_hold = HOLD_ID;
               if (FLUSH_EN) begin
                  w_state_nxt = S_FLUSH;
                  w_cnt_nxt   = FLUSH_INIT;
               end
            end
         end
         S_FLUSH: begin
            // A jump here was fetched down the wrong path, so only interrupts may redirect.
            w_fsm_hold = HOLD_ID;
            if (bus.int_req_i) begin
               w_jump      = 1'b1;
               w_addr      = bus.int_addr_i;
               w_state_nxt = S_INT;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt <= 3'd1) begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = 3'd0;
               end
            end
         end
         S_INT: begin
            w_fsm_hold = HOLD_ID;
            if (bus.int_done_i) begin
               if (FLUSH_EN) begin
                  w_state_nxt = S_FLUSH;
                  w_cnt_nxt   = FLUSH_INIT;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         default: begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   // Hold levels are ordered by severity, so merging is a max.
   always_comb begin
      w_hold = w_fsm_hold;
      if (bus.bus_hold_i && (HOLD_PC > w_hold)) w_hold = HOLD_PC;
      if (bus.ex_hold_i) w_hold = HOLD_ID;
   end

   assign bus.hold_flag_o = rst_n_i ? w_hold : HOLD_ID;
   assign bus.jump_flag_o = rst_n_i & w_jump;
   assign bus.jump_addr_o = rst_n_i ? w_addr : '0;
   assign bus.busy_o      = rst_n_i & (r_state != S_RUN);

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cnt, r_redir_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_stall_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if ((w_hold != HOLD_NONE) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_jump && (r_redir_cnt != '1)) r_redir_cnt <= r_redir_cnt + 32'd1;
      end
   end

   assign bus.stall_cnt_o    = r_stall_cnt;
   assign bus.redirect_cnt_o = r_redir_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle model comparison plus directed literal checks.
// Build with PIPE_CTRL_PERF_EN to also cover the performance counters.
module tb_pipe_ctrl;
   localparam int FC = 2;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.ADDR_W(AW)) u_if ();
   pipe_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(AW)) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (u_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: "in interrupt" flag plus number of forced-hold cycles still owed.
   bit          m_int;
   int          m_left;
   int unsigned m_stall, m_redir;
   logic [2:0]  e_hold;
   logic        e_jump, e_busy;
   logic [31:0] e_addr;

   always_comb begin
      e_hold = 3'd3;
      e_jump = 1'b0;
      e_addr = '0;
      e_busy = 1'b0;
      if (rst_n) begin
         e_busy = m_int || (m_left > 0);
         if (!m_int && u_if.int_req_i) begin
            e_jump = 1'b1;
            e_addr = u_if.int_addr_i;
         end else if (!m_int && m_left == 0 && u_if.jump_flag_i) begin
            e_jump = 1'b1;
            e_addr = u_if.jump_addr_i;
         end
         e_hold = (e_busy || e_jump || u_if.ex_hold_i) ? 3'd3 : (u_if.bus_hold_i ? 3'd1 : 3'd0);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_int   <= 1'b0;
         m_left  <= 0;
         m_stall <= 0;
         m_redir <= 0;
      end else begin
         if (e_hold != 3'd0) m_stall <= m_stall + 1;
         if (e_jump) m_redir <= m_redir + 1;
         if (!m_int && u_if.int_req_i) begin
            m_int  <= 1'b1;
            m_left <= 0;
         end else if (m_int) begin
            if (u_if.int_done_i) begin
               m_int  <= 1'b0;
               m_left <= FC - 1;
            end
         end else if (e_jump) m_left <= FC - 1;
         else if (m_left > 0) m_left <= m_left - 1;
      end
   end

   always @(negedge clk) begin
      chk("hold_flag_o", 64'(u_if.hold_flag_o), 64'(e_hold));
      chk("jump_flag_o", 64'(u_if.jump_flag_o), 64'(e_jump));
      chk("jump_addr_o", 64'(u_if.jump_addr_o), 64'(e_addr));
      chk("busy_o",      64'(u_if.busy_o),      64'(e_busy));
`ifdef PIPE_CTRL_PERF_EN
      chk("stall_cnt_o",    64'(u_if.stall_cnt_o),    64'(m_stall));
      chk("redirect_cnt_o", 64'(u_if.redirect_cnt_o), 64'(m_redir));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      u_if.jump_flag_i = 1'b0;
      u_if.jump_addr_i = '0;
      u_if.ex_hold_i   = 1'b0;
      u_if.bus_hold_i  = 1'b0;
      u_if.int_req_i   = 1'b0;
      u_if.int_addr_i  = '0;
      u_if.int_done_i  = 1'b0;
   endtask

   initial begin
      clr();
      #2;
      chk("rst_hold", 64'(u_if.hold_flag_o), 64'd3);
      chk("rst_busy", 64'(u_if.busy_o), 64'd0);
      chk("rst_jump", 64'(u_if.jump_flag_o), 64'd0);
      #21 rst_n = 1'b1;
      step();
      chk("run_hold", 64'(u_if.hold_flag_o), 64'd0);
      chk("run_busy", 64'(u_if.busy_o), 64'd0);

      // Jump: redirect cycle plus one flush cycle.
      u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h100;
      #1;
      chk("jmp_flag", 64'(u_if.jump_flag_o), 64'd1);
      chk("jmp_addr", 64'(u_if.jump_addr_o), 64'h100);
      chk("jmp_hold", 64'(u_if.hold_flag_o), 64'd3);
      step(); clr(); #1;
      chk("flush_hold", 64'(u_if.hold_flag_o), 64'd3);
      chk("flush_busy", 64'(u_if.busy_o), 64'd1);
      step(); #1;
      chk("post_flush_hold", 64'(u_if.hold_flag_o), 64'd0);
      chk("post_flush_busy", 64'(u_if.busy_o), 64'd0);

      // Interrupt beats a same-cycle jump.
      u_if.int_req_i = 1'b1; u_if.int_addr_i = 32'h80;
      u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h200;
      #1;
      chk("int_addr", 64'(u_if.jump_addr_o), 64'h80);
      chk("int_flag", 64'(u_if.jump_flag_o), 64'd1);
      step(); clr(); #1;
      chk("int_hold", 64'(u_if.hold_flag_o), 64'd3);
      chk("int_busy", 64'(u_if.busy_o), 64'd1);
      step(); step();
      u_if.int_done_i = 1'b1; #1;
      chk("done_hold", 64'(u_if.hold_flag_o), 64'd3);
      step(); clr(); #1;
      chk("done_flush_hold", 64'(u_if.hold_flag_o), 64'd3);
      step(); #1;
      chk("done_run_hold", 64'(u_if.hold_flag_o), 64'd0);
      chk("done_run_busy", 64'(u_if.busy_o), 64'd0);

      // Stall merge.
      u_if.bus_hold_i = 1'b1; #1;
      chk("bus_hold", 64'(u_if.hold_flag_o), 64'd1);
      u_if.ex_hold_i = 1'b1; #1;
      chk("ex_bus_hold", 64'(u_if.hold_flag_o), 64'd3);
      clr(); #1;
      chk("no_hold", 64'(u_if.hold_flag_o), 64'd0);
      step();

      // Jump during flush is dropped; flush length unchanged.
      u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h100;
      step();
      u_if.jump_addr_i = 32'h300; #1;
      chk("flush_jmp_drop", 64'(u_if.jump_flag_o), 64'd0);
      chk("flush_jmp_hold", 64'(u_if.hold_flag_o), 64'd3);
      step(); clr(); #1;
      chk("flush_len_hold", 64'(u_if.hold_flag_o), 64'd0);
      chk("flush_len_busy", 64'(u_if.busy_o), 64'd0);

      // Reset while in S_INT.
      u_if.int_req_i = 1'b1; u_if.int_addr_i = 32'h40;
      step(); clr(); step(); #1;
      chk("pre_rst_busy", 64'(u_if.busy_o), 64'd1);
      rst_n = 1'b0; #1;
      chk("mid_rst_hold", 64'(u_if.hold_flag_o), 64'd3);
      chk("mid_rst_busy", 64'(u_if.busy_o), 64'd0);
      chk("mid_rst_jump", 64'(u_if.jump_flag_o), 64'd0);
`ifdef PIPE_CTRL_PERF_EN
      chk("mid_rst_stall_cnt", 64'(u_if.stall_cnt_o), 64'd0);
`endif
      #4 rst_n = 1'b1;
      step();
      chk("rel_busy", 64'(u_if.busy_o), 64'd0);
      chk("rel_hold", 64'(u_if.hold_flag_o), 64'd0);
`ifdef PIPE_CTRL_PERF_EN
      chk("rel_stall_cnt", 64'(u_if.stall_cnt_o), 64'd0);
      u_if.bus_hold_i = 1'b1;
      step(); step(); step();
      clr(); #1;
      chk("stall_cnt_3", 64'(u_if.stall_cnt_o), 64'd3);
`endif
      step();

      // Random traffic, checked every cycle by the model.
      for (int i = 0; i < 300; i++) begin
         u_if.jump_flag_i = ($urandom_range(0, 9) < 3);
         u_if.jump_addr_i = $urandom;
         u_if.int_req_i   = ($urandom_range(0, 19) == 0);
         u_if.int_addr_i  = $urandom;
         u_if.int_done_i  = ($urandom_range(0, 4) == 0);
         u_if.ex_hold_i   = ($urandom_range(0, 9) == 0);
         u_if.bus_hold_i  = ($urandom_range(0, 6) == 0);
         if (i == 150) begin
            #1 rst_n = 1'b0;
            #3 rst_n = 1'b1;
         end
         step();
      end
      clr();
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
